// File: rtl/panel_debounce.sv
// Front-panel input conditioner: per-channel synchroniser, stable-count debouncer,
// polarity correction, press/release edge pulses and an optional auto-repeat pulse train.
module panel_debounce #(
    parameter int              N_CH         = 8,
    parameter int              SYNC_STAGES  = 2,
    parameter int              STABLE_CYC   = 16,
    parameter logic [N_CH-1:0] INVERT       = '0,
    parameter int              REPEAT_DELAY = 10,
    parameter int              REPEAT_RATE  = 3
) (
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic [N_CH-1:0] raw_i,
    input  logic [N_CH-1:0] rpt_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] rpt_o
);

    localparam int CNT_W   = $clog2(STABLE_CYC);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [RC_W-1:0]  DELAY_M1 = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  RATE_M1  = RC_W'(REPEAT_RATE - 1);

    // Synchroniser flops reset to INVERT so the corrected level reads idle out of reset.
    logic [N_CH-1:0] r_sync [SYNC_STAGES];
    logic [N_CH-1:0] w_s;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= INVERT;
            end
        end else begin
            r_sync[0] <= raw_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1] ^ INVERT;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [RC_W-1:0]  r_rc;
        logic             r_first;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             r_rpt;
        logic             w_flip;
        logic             w_rise;
        logic             w_fall;

        assign w_flip = (w_s[i] != r_level) && (r_cnt == CNT_LAST);
        assign w_rise = w_flip &&  w_s[i];
        assign w_fall = w_flip && !w_s[i];

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                if (w_s[i] == r_level) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_cnt   <= '0;
                    r_level <= w_s[i];
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        // The release edge sees the old level still high, so it must mask the repeat decision.
        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                r_rc    <= '0;
                r_first <= 1'b0;
                r_rpt   <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (w_rise) begin
                    r_rc    <= '0;
                    r_first <= 1'b1;
                end else if (w_fall || !r_level || !rpt_en_i[i]) begin
                    r_rc <= '0;
                    if (!rpt_en_i[i]) begin
                        r_first <= 1'b0;
                    end
                end else if (r_rc == (r_first ? DELAY_M1 : RATE_M1)) begin
                    r_rpt   <= 1'b1;
                    r_rc    <= '0;
                    r_first <= 1'b0;
                end else begin
                    r_rc <= r_rc + RC_W'(1);
                end
            end
        end

        assign level_o[i]   = r_level;
        assign press_o[i]   = r_press;
        assign release_o[i] = r_release;
        assign rpt_o[i]     = r_rpt;
    end

endmodule

// File: tb/tb_panel_debounce.sv
// Directed bench for panel_debounce with six channels, short debounce and ch5 active-low.
module tb_panel_debounce;

    logic       clk;
    logic       srst;
    logic [5:0] raw;
    logic [5:0] rpt_en;
    logic [5:0] level;
    logic [5:0] press;
    logic [5:0] rel;
    logic [5:0] rpt;

    int n_checks = 0;
    int n_errors = 0;

    panel_debounce #(
        .N_CH(6), .SYNC_STAGES(2), .STABLE_CYC(4),
        .INVERT(6'b100000), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .clk_i(clk), .srst_i(srst), .raw_i(raw), .rpt_en_i(rpt_en),
        .level_o(level), .press_o(press), .release_o(rel), .rpt_o(rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are read and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  acc;
    logic [30:0] rpt_log;
    logic [30:0] rpt_exp;
    int          t_press;

    initial begin
        srst   = 1'b1;
        raw    = 6'b100000;
        rpt_en = 6'b000000;
        tick();
        check("rst_out", {level, press, rel, rpt}, 24'h0);
        tick();
        srst = 1'b0;

        // Idle after reset with ch5 pin high (released, active-low).
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            acc |= level | press | rel | rpt;
        end
        check("reset_idle", acc, 6'b0);

        // ch0 press and release latency.
        raw = 6'b100001;
        repeat (5) tick();
        check("ch0_lvl_e5", level, 6'b000000);
        tick();
        check("ch0_lvl_e6", level, 6'b000001);
        check("ch0_press_e6", press, 6'b000001);
        check("ch0_rel_e6", rel, 6'b000000);
        tick();
        check("ch0_press_1cyc", press, 6'b000000);
        raw = 6'b100000;
        repeat (5) tick();
        check("ch0_rel_e5", rel, 6'b000000);
        tick();
        check("ch0_rel_e6", rel, 6'b000001);
        check("ch0_lvl_off", level, 6'b000000);
        tick();
        check("ch0_rel_1cyc", rel, 6'b000000);

        // ch1 chatter 1,1,1,0 never reaches the stable count.
        acc = '0;
        for (int k = 0; k < 40; k++) begin
            raw[1] = ((k % 4) != 3);
            tick();
            acc |= level | press | rel;
        end
        raw[1] = 1'b0;
        repeat (8) begin
            tick();
            acc |= level | press | rel;
        end
        check("ch1_chatter", acc, 6'b0);

        // ch2 auto-repeat, then disable and release.
        rpt_en[2] = 1'b1;
        raw[2]    = 1'b1;
        t_press   = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (press[2]) begin
                t_press = k;
                break;
            end
        end
        check("ch2_press_lat", t_press, 6);
        rpt_log = '0;
        rpt_exp = '0;
        rpt_exp[10] = 1'b1;
        rpt_exp[13] = 1'b1;
        rpt_exp[16] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            rpt_log[k] = rpt[2];
            if (k == 17) rpt_en[2] = 1'b0;
        end
        check("ch2_rpt_train", rpt_log, rpt_exp);
        raw[2] = 1'b0;
        acc = '0;
        repeat (5) begin
            tick();
            acc |= rpt;
        end
        tick();
        acc |= rpt;
        check("ch2_rel", rel, 6'b000100);
        check("ch2_no_rpt", acc, 6'b0);

        // Active-low ch5 with ch0 and ch3 pressed at the same time.
        raw = 6'b001001;
        repeat (5) tick();
        check("multi_press_e5", press, 6'b000000);
        tick();
        check("multi_press_e6", press, 6'b101001);
        check("multi_lvl", level, 6'b101001);
        raw = 6'b100000;
        repeat (6) tick();
        check("multi_rel", rel, 6'b101001);
        check("multi_lvl_off", level, 6'b000000);

        // Reset mid-hold on ch0: outputs clear without release, then press re-debounced.
        raw = 6'b100001;
        repeat (6) tick();
        check("hold_press", press, 6'b000001);
        repeat (2) tick();
        srst = 1'b1;
        tick();
        check("mid_rst_out", {level, press, rel, rpt}, 24'h0);
        srst = 1'b0;
        acc = '0;
        repeat (5) begin
            tick();
            acc |= rel;
        end
        check("post_rst_e5", {level, press}, 12'h0);
        tick();
        acc |= rel;
        check("post_rst_press", press, 6'b000001);
        check("post_rst_no_rel", acc, 6'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
